// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding and frame constants for the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam int         FRAME_BITS = 11;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronizes both PS/2 pins and flags falling edges of the PS/2 clock
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);
  logic [SYNC_STAGES-1:0] clk_q, clk_d, dat_q, dat_d;
  logic prev_q, prev_d;
  // shift raw pins through the synchronizer chains; keep last synced clock for edge detect
  always_comb begin
    clk_d  = {clk_q[SYNC_STAGES-2:0], ps2_clk};
    dat_d  = {dat_q[SYNC_STAGES-2:0], ps2_data};
    prev_d = clk_q[SYNC_STAGES-1];
  end
  // bus idles high, so everything resets to 1 to avoid a phantom edge
  always_ff @(posedge clk) begin
    if (res) begin
      clk_q  <= '1;
      dat_q  <= '1;
      prev_q <= 1'b1;
    end else begin
      clk_q  <= clk_d;
      dat_q  <= dat_d;
      prev_q <= prev_d;
    end
  end
  assign data_s = dat_q[SYNC_STAGES-1];
  assign fall   = prev_q & ~clk_q[SYNC_STAGES-1];
endmodule

// File: rtl/ps2_frame_ctrl.sv
// ps2_frame_ctrl: frames, checks and prefix-folds PS/2 keyboard packets; PS2_TIMEOUT_EN adds a stall timeout
module ps2_frame_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_extended,
  output logic       frame_err,
  output logic       busy
);
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("ps2_frame_ctrl: SYNC_STAGES and TIMEOUT_CYCLES must be at least 2");
  end
  logic data_s, fall, good;
  ps2_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, code_q, code_d;
  logic parity_q, parity_d, ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
  logic rel_q, rel_d, ext_q, ext_d, valid_q, valid_d, err_q, err_d;
`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] to_q, to_d;
`endif
  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .res(res), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .data_s(data_s), .fall(fall)
  );
  assign good = (^{shift_q, parity_q}) & data_s;
  // frame FSM: sample data on each PS/2 falling edge, evaluate at the stop bit
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    code_d     = code_q;
    rel_d      = rel_q;
    ext_d      = ext_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
`ifdef PS2_TIMEOUT_EN
    to_d       = '0;
`endif
    if (fall) begin
      case (state_q)
        IDLE: if (!data_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          shift_d[bit_cnt_q] = data_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          state_d            = bit_cnt_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          parity_d = data_s;
          state_d  = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!good) begin
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end else if (shift_q == EXT_CODE) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == BREAK_CODE) begin
            rel_pend_d = 1'b1;
          end else begin
            code_d     = shift_q;
            ext_d      = ext_pend_q;
            rel_d      = rel_pend_q;
            valid_d    = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end
        end
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    else if (state_q != IDLE) begin
      if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d    = IDLE;
        err_d      = 1'b1;
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
`endif
  end
  // state and output registers; reset discards any partial frame silently
  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      ext_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
      code_q     <= '0;
      rel_q      <= 1'b0;
      ext_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
      code_q     <= code_d;
      rel_q      <= rel_d;
      ext_q      <= ext_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
`ifdef PS2_TIMEOUT_EN
      to_q       <= to_d;
`endif
    end
  end
  assign key_code     = code_q;
  assign key_valid    = valid_q;
  assign key_release  = rel_q;
  assign key_extended = ext_q;
  assign frame_err    = err_q;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_ps2_frame_ctrl.sv
// tb_ps2_frame_ctrl: scoreboard bench driving PS/2 frames and checking key events and errors
module tb_ps2_frame_ctrl;
  logic clk = 1'b0, res = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] key_code;
  logic key_valid, key_release, key_extended, frame_err, busy;
  typedef struct packed {logic [7:0] code; logic rel; logic ext;} ev_t;
  ev_t exp_q[$];
  ev_t ev;
  int checks = 0, errors = 0, n_valid = 0, n_err = 0;
  ps2_frame_ctrl #(.TIMEOUT_CYCLES(5000), .SYNC_STAGES(2)) dut (
    .clk(clk), .res(res), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_valid(key_valid), .key_release(key_release),
    .key_extended(key_extended), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!res) begin
      if (key_valid) begin
        n_valid++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_key_valid code=%h rel=%b ext=%b", key_code, key_release, key_extended);
        end else begin
          ev = exp_q.pop_front();
          if ({key_code, key_release, key_extended} !== ev) begin
            errors++;
            $display("FAIL key_event got code=%h rel=%b ext=%b want code=%h rel=%b ext=%b",
                     key_code, key_release, key_extended, ev.code, ev.rel, ev.ext);
          end
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_valid got %b want 0", busy);
        end
      end
      if (frame_err) n_err++;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, ~^b ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(10);
      ps2_clk = 1'b0;
      tick(10);
      ps2_clk = 1'b1;
    end
    tick(2);
    ps2_data = 1'b1;
    tick(20);
  endtask
  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask
  task automatic expect_counts(input string name, input int v0, input int e0, input int dv, input int de);
    checks++;
    if (n_valid - v0 !== dv || n_err - e0 !== de) begin
      errors++;
      $display("FAIL %s counts got valid=%0d err=%0d want valid=%0d err=%0d", name, n_valid - v0, n_err - e0, dv, de);
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s drain got pending=%0d busy=%b want 0 0", name, exp_q.size(), busy);
    end
  endtask
  task automatic test_reset();
    res = 1'b1;
    tick(4);
    res = 1'b0;
    tick(1);
    checks++;
    if ({key_code, key_valid, key_release, key_extended, frame_err, busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got code=%h v=%b r=%b e=%b err=%b busy=%b want all 0",
               key_code, key_valid, key_release, key_extended, frame_err, busy);
    end
  endtask
  task automatic test_make();
    int v0 = n_valid, e0 = n_err;
    exp_q.push_back('{8'h1C, 1'b0, 1'b0});
    send(8'h1C);
    expect_counts("make_1c", v0, e0, 1, 0);
  endtask
  task automatic test_break();
    int v0 = n_valid, e0 = n_err;
    exp_q.push_back('{8'h1C, 1'b1, 1'b0});
    send(8'hF0);
    checks++;
    if (n_valid != v0) begin
      errors++;
      $display("FAIL break_prefix_valid got %0d want 0", n_valid - v0);
    end
    send(8'h1C);
    exp_q.push_back('{8'h1C, 1'b0, 1'b0});
    send(8'h1C);
    expect_counts("break_1c", v0, e0, 2, 0);
  endtask
  task automatic test_ext_break();
    int v0 = n_valid, e0 = n_err;
    exp_q.push_back('{8'h74, 1'b1, 1'b1});
    send(8'hE0); send(8'hF0); send(8'h74);
    exp_q.push_back('{8'h75, 1'b1, 1'b1});
    send(8'hF0); send(8'hE0); send(8'hE0); send(8'h75);
    exp_q.push_back('{8'h6B, 1'b0, 1'b1});
    send(8'hE0); send(8'h6B);
    expect_counts("ext_break", v0, e0, 3, 0);
  endtask
  task automatic test_parity_err();
    int v0 = n_valid, e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    expect_counts("parity_err", v0, e0, 0, 1);
    checks++;
    if (key_code !== 8'h6B) begin
      errors++;
      $display("FAIL parity_hold_code got %h want 6b", key_code);
    end
    exp_q.push_back('{8'h32, 1'b0, 1'b0});
    send(8'h32);
    expect_counts("after_parity", v0, e0, 1, 1);
  endtask
  task automatic test_stop_err();
    int v0 = n_valid, e0 = n_err;
    send(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    exp_q.push_back('{8'h1C, 1'b0, 1'b0});
    send(8'h1C);
    expect_counts("stop_err_clears_prefix", v0, e0, 1, 1);
  endtask
  task automatic test_false_start();
    int v0 = n_valid, e0 = n_err;
    ps2_data = 1'b1;
    tick(10);
    ps2_clk = 1'b0;
    tick(10);
    ps2_clk = 1'b1;
    tick(10);
    expect_counts("false_start", v0, e0, 0, 0);
  endtask
  task automatic test_timeout();
`ifdef PS2_TIMEOUT_EN
    int v0 = n_valid, e0 = n_err;
    send_frame(8'h5A, 1'b0, 1'b1, 5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_busy_before got %b want 1", busy);
    end
    tick(5100);
    expect_counts("timeout", v0, e0, 0, 1);
    exp_q.push_back('{8'h32, 1'b0, 1'b0});
    send(8'h32);
    expect_counts("after_timeout", v0, e0, 1, 1);
`endif
  endtask
  task automatic test_reset_mid();
    int v0 = n_valid, e0 = n_err;
    send(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, 6);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before got %b want 1", busy);
    end
    res = 1'b1;
    tick(1);
    res = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_busy got %b want 0", busy);
    end
    tick(5);
    exp_q.push_back('{8'h1C, 1'b0, 1'b0});
    send(8'h1C);
    expect_counts("reset_mid", v0, e0, 1, 0);
  endtask
  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext_break();
    test_parity_err();
    test_stop_err();
    test_false_start();
    test_timeout();
    test_reset_mid();
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
